frame_scheduler: RTL
====================

Name: frame_scheduler

Overview:
- Sequences the game state that feeds the VGA renderer so the picture never tears.
- Game logic hands over a complete state (ball x/y, left/right paddle bitmaps) with a valid/ready handshake. The block holds it in a shadow register and commits it to the display registers only at the start of vertical sync.
- It also issues a game_tick every TICK_FRAMES frames, so game logic runs at a fixed frame-locked rate.
- Sits between the game logic and the renderer, in the 31.5 MHz pixel-clock domain.

Parameters:
- TICK_FRAMES, 4, frames per game_tick; legal range 1..255.
- VSYNC_ACTIVE_HIGH, 0, vsync polarity: 0 = active-low sync pulse.
- RST_BALL_X, 5'd15, display ball x after reset.
- RST_BALL_Y, 5'd15, display ball y after reset.
- RST_PADDLE, 32'h0000_7800, both display paddle bitmaps after reset.

Ports:
- clk  in  1  pixel clock, 31.5 MHz
- reset  in  1  asynchronous, active-high
- vsync  in  1  vsync from the sync generator, same clock domain
- pause  in  1  1 = freeze commits, ticks and frame count
- upd_valid  in  1  game logic offers a new state
- upd_ready  out  1  shadow register empty; update accepted when valid&ready
- upd_ball_x  in  5  new ball column
- upd_ball_y  in  5  new ball row
- upd_lpaddle  in  32  new left paddle bitmap
- upd_rpaddle  in  32  new right paddle bitmap
- disp_ball_x  out  5  committed ball column, to renderer
- disp_ball_y  out  5  committed ball row, to renderer
- disp_lpaddle  out  32  committed left paddle, to renderer
- disp_rpaddle  out  32  committed right paddle, to renderer
- game_tick  out  1  one-cycle pulse; game logic computes the next state
- late_count  out  8  saturating count of frames where an update was due but missing

Behaviour:
Clock and reset:
- Single clock, clk. reset is asynchronous, active-high; all state clears immediately on assertion.
- Reset values:
  - disp_* = RST_* parameters.
  - game_tick = 0, late_count = 0.
  - shadow_full = 0, tick_outstanding = 0, frame_cnt = 0.
  - vs_q = the asserted vsync level. This stops a spurious frame start on the first cycle after reset; the first frame_start comes on the next genuine edge.
- upd_ready is forced 0 while reset is high.

frame_start:
- vs_act = vsync XNOR VSYNC_ACTIVE_HIGH.
- vs_q is vs_act registered.
- frame_start = vs_act & ~vs_q, a combinational one-cycle strobe in cycle N.

Shadow handshake (states EMPTY / FULL):
- upd_ready = ~shadow_full (outside reset).
- EMPTY: valid&ready captures all four fields into the shadow and moves to FULL.
- FULL: upd_ready = 0; upd_valid is ignored.
- On frame_start with FULL and pause = 0: the shadow is copied to disp_*, visible in cycle N+1, and the state returns to EMPTY.
- An update accepted in the same cycle as frame_start (only possible from EMPTY) waits for the next frame_start.
- Under pause the shadow is held FULL and disp_* does not change.

Tick counter:
- On frame_start with pause = 0: frame_cnt increments, wrapping from TICK_FRAMES-1 to 0.
- On the wrap, game_tick is registered high for exactly cycle N+1, the same cycle the new disp_* first appears.
- With TICK_FRAMES = 1, game_tick fires on every frame.
- pause = 1 holds frame_cnt; game_tick stays 0.

late_count:
- tick_outstanding is set when game_tick = 1 and cleared by any valid&ready handshake. A handshake in the same cycle as game_tick wins, i.e. clears it.
- On frame_start with pause = 0, tick_outstanding = 1 and shadow_full = 0: late_count increments, saturating at 255.
- Reset is the only way to clear late_count.

Other boundary rules:
- disp_* only ever changes in the cycle after frame_start, or on reset. It never changes mid-frame.
- pause changes take effect on the next frame_start evaluation. No partial commit is possible.
- Reset during FULL discards the shadow contents.

Decomposition:
- pong_pkg holds:
  - GRID_BITS = 5 and PADDLE_BITS = 32.
  - A packed struct game_state_t {ball_x, ball_y, lpaddle, rpaddle} for the shadow and display registers.
  - Reset-default constants.
- One sub-module, vsync_edge: polarity normalisation, vs_q register (reset to asserted level) and frame_start output.
- The handshake, tick counter and late counter stay in frame_scheduler.

Test Plan:
1. Reset, then an update (x=3, y=7, lpaddle=32'hF0, rpaddle=32'hF00) mid-frame:
   - upd_ready drops to 0.
   - disp_* keeps its reset values until the vsync falling edge.
   - In cycle N+1, disp_ball_x = 3, disp_ball_y = 7; upd_ready returns to 1.
2. TICK_FRAMES = 4, run 8 frames: game_tick pulses exactly twice, each 1 cycle wide, in the cycle after the 4th and 8th frame_start.
3. Second upd_valid while FULL: not accepted (ready = 0). Only the first update is committed; the second is accepted in the cycle after the commit.
4. After game_tick, no update for 3 frames: late_count = 1, 2, 3. Then a handshake followed by a commit leaves late_count at 3.
5. pause = 1 across two frame_starts with the shadow FULL: disp_* unchanged, no game_tick. After pause = 0, the next frame_start commits.
6. Async reset asserted mid-cycle while FULL with late_count = 5:
   - Immediately: outputs return to RST_*, late_count = 0, upd_ready = 0.
   - vsync held asserted through the release: no frame_start until the next genuine edge.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pkg
// Shared widths, game-state record and reset defaults for the Pong
// display path.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package pong_pkg;

  localparam int GRID_BITS   = 5;
  localparam int PADDLE_BITS = 32;

  // One complete picture's worth of game state
  typedef struct packed {
    logic [GRID_BITS-1:0]   ball_x;
    logic [GRID_BITS-1:0]   ball_y;
    logic [PADDLE_BITS-1:0] lpaddle;
    logic [PADDLE_BITS-1:0] rpaddle;
  } game_state_t;

  // Shadow register occupancy
  typedef enum logic [0:0] {
    SHADOW_EMPTY = 1'b0,
    SHADOW_FULL  = 1'b1
  } shadow_state_t;

  localparam logic [GRID_BITS-1:0]   DEF_BALL_X = 5'd15;
  localparam logic [GRID_BITS-1:0]   DEF_BALL_Y = 5'd15;
  localparam logic [PADDLE_BITS-1:0] DEF_PADDLE = 32'h0000_7800;

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_scheduler_vsync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vsync_edge
// Normalises vsync polarity and produces a one-cycle frame_start strobe on
// the leading edge of the sync pulse.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module vsync_edge #(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_start
);

  logic vs_act;
  logic vs_q;

  // 1 whenever the sync pulse is in its asserted phase
  assign vs_act = ~(vsync ^ VSYNC_ACTIVE_HIGH);

  // Previous asserted state; resets to "asserted" so a pulse already in
  // progress at reset release is not mistaken for a new frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_q <= 1'b1;
    else       vs_q <= vs_act;
  end

  assign frame_start = vs_act & ~vs_q;

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_scheduler
// Holds game state offered by game logic in a shadow register and commits it
// to the renderer-facing display registers only at vsync start; issues a
// frame-locked game_tick and counts frames where game logic was late.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module frame_scheduler
  import pong_pkg::*;
#(
  parameter int                     TICK_FRAMES       = 4,
  parameter bit                     VSYNC_ACTIVE_HIGH = 1'b0,
  parameter logic [GRID_BITS-1:0]   RST_BALL_X        = DEF_BALL_X,
  parameter logic [GRID_BITS-1:0]   RST_BALL_Y        = DEF_BALL_Y,
  parameter logic [PADDLE_BITS-1:0] RST_PADDLE        = DEF_PADDLE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   pause,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [GRID_BITS-1:0]   upd_ball_x,
  input  logic [GRID_BITS-1:0]   upd_ball_y,
  input  logic [PADDLE_BITS-1:0] upd_lpaddle,
  input  logic [PADDLE_BITS-1:0] upd_rpaddle,
  output logic [GRID_BITS-1:0]   disp_ball_x,
  output logic [GRID_BITS-1:0]   disp_ball_y,
  output logic [PADDLE_BITS-1:0] disp_lpaddle,
  output logic [PADDLE_BITS-1:0] disp_rpaddle,
  output logic                   game_tick,
  output logic [7:0]             late_count
);

  localparam logic [7:0] TICK_LAST = 8'(TICK_FRAMES - 1);
  localparam game_state_t RST_STATE = '{
    ball_x:  RST_BALL_X,
    ball_y:  RST_BALL_Y,
    lpaddle: RST_PADDLE,
    rpaddle: RST_PADDLE
  };

  shadow_state_t state;
  game_state_t   shadow;
  game_state_t   disp;
  logic [7:0]    frame_cnt;
  logic          tick_outstanding;
  logic          frame_start;
  logic          frame_go;
  logic          handshake;
  logic          shadow_full;

  vsync_edge #(
    .VSYNC_ACTIVE_HIGH (VSYNC_ACTIVE_HIGH)
  ) u_vsync_edge (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  assign shadow_full = (state == SHADOW_FULL);
  assign upd_ready   = ~reset & ~shadow_full;
  assign handshake   = upd_valid & upd_ready;
  // A frame boundary that is allowed to advance game state
  assign frame_go    = frame_start & ~pause;

  // Shadow handshake and commit of the shadow into the display registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SHADOW_EMPTY;
      shadow <= RST_STATE;
      disp   <= RST_STATE;
    end else begin
      case (state)
        SHADOW_EMPTY: begin
          if (handshake) begin
            shadow <= '{ball_x: upd_ball_x, ball_y: upd_ball_y,
                        lpaddle: upd_lpaddle, rpaddle: upd_rpaddle};
            state  <= SHADOW_FULL;
          end
        end
        SHADOW_FULL: begin
          if (frame_go) begin
            disp  <= shadow;
            state <= SHADOW_EMPTY;
          end
        end
        default: state <= SHADOW_EMPTY;
      endcase
    end
  end

  // Frame counter and the registered tick pulse on its wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 8'd0;
      game_tick <= 1'b0;
    end else begin
      game_tick <= 1'b0;
      if (frame_go) begin
        if (frame_cnt == TICK_LAST) begin
          frame_cnt <= 8'd0;
          game_tick <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Lateness tracking: a tick not yet answered by an update, counted at the
  // next frame if the shadow is still empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_outstanding <= 1'b0;
      late_count       <= 8'd0;
    end else begin
      if (handshake)      tick_outstanding <= 1'b0;
      else if (game_tick) tick_outstanding <= 1'b1;
      if (frame_go && tick_outstanding && !shadow_full)
        late_count <= sat_inc8(late_count);
    end
  end

  assign disp_ball_x  = disp.ball_x;
  assign disp_ball_y  = disp.ball_y;
  assign disp_lpaddle = disp.lpaddle;
  assign disp_rpaddle = disp.rpaddle;

endmodule
`default_nettype wire
